// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack handshake to a
// variable-latency instruction memory and feeds IF/ID, honouring stall and redirect.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_addr_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_data_i,
   output logic [31:0] instr_addr_o,
   output logic [31:0] instr_o,
   output logic        valid_o
);

   typedef enum logic [1:0] {StFetch, StDrop, StHold} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] tgt_q, tgt_d;
   logic [31:0] buf_addr_q, buf_addr_d;
   logic [31:0] buf_instr_q, buf_instr_d;

   logic [31:0] redir_addr;
   logic [31:0] pc_inc;
   logic        req;
   logic        valid;
   logic [31:0] instr;
   logic [31:0] instr_addr;
   logic        unused_redir_lsb;

   assign redir_addr       = {redirect_addr_i[31:2], 2'b00};
   assign pc_inc           = pc_q + 32'd4;
   assign unused_redir_lsb = ^redirect_addr_i[1:0];

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      tgt_d       = tgt_q;
      buf_addr_d  = buf_addr_q;
      buf_instr_d = buf_instr_q;
      req         = 1'b0;
      valid       = 1'b0;
      instr       = buf_instr_q;
      instr_addr  = buf_addr_q;

      unique case (state_q)
         StFetch: begin
            req        = 1'b1;
            valid      = imem_ack_i & ~redirect_i;
            instr      = imem_data_i;
            instr_addr = pc_q;
            if (imem_ack_i) begin
               if (redirect_i) begin
                  pc_d = redir_addr;
               end else begin
                  pc_d = pc_inc;
                  if (stall_i) begin
                     buf_addr_d  = pc_q;
                     buf_instr_d = imem_data_i;
                     state_d     = StHold;
                  end
               end
            end else if (redirect_i) begin
               // Request cannot be aborted; wait for its ack before fetching the target.
               tgt_d   = redir_addr;
               state_d = StDrop;
            end
         end
         StDrop: begin
            req = 1'b1;
            if (redirect_i) begin
               tgt_d = redir_addr;
            end
            if (imem_ack_i) begin
               pc_d    = redirect_i ? redir_addr : tgt_q;
               state_d = StFetch;
            end
         end
         StHold: begin
            valid = ~redirect_i;
            if (redirect_i) begin
               pc_d    = redir_addr;
               state_d = StFetch;
            end else if (!stall_i) begin
               state_d = StFetch;
            end
         end
         default: begin
            state_d = StFetch;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StFetch;
         pc_q        <= {RESET_PC[31:2], 2'b00};
         tgt_q       <= 32'h0;
         buf_addr_q  <= 32'h0;
         buf_instr_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         tgt_q       <= tgt_d;
         buf_addr_q  <= buf_addr_d;
         buf_instr_q <= buf_instr_d;
      end
   end

   // Outputs are forced quiet for as long as reset is held.
   assign imem_req_o   = req & ~rst_i;
   assign imem_addr_o  = rst_i ? 32'h0 : pc_q;
   assign valid_o      = valid & ~rst_i;
   assign instr_o      = rst_i ? 32'h0 : instr;
   assign instr_addr_o = rst_i ? 32'h0 : instr_addr;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural fetch model.
module tb_if_fetch_stage;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        stall_i = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_addr_i = 32'h0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i = 1'b0;
   logic [31:0] imem_data_i = 32'h0;
   logic [31:0] instr_addr_o;
   logic [31:0] instr_o;
   logic        valid_o;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // Behavioural model: next fetch address, whether a wrong-path fetch is still in
   // flight (and where to go after it), and whether an instruction is parked.
   logic [31:0] m_pc = 32'h0;
   logic        m_flushing = 1'b0;
   logic [31:0] m_tgt = 32'h0;
   logic        m_held = 1'b0;
   logic [31:0] m_held_addr = 32'h0;
   logic [31:0] m_held_instr = 32'h0;

   always #5 clk_i = ~clk_i;

   if_fetch_stage #(
      .RESET_PC(32'h0000_0000)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .stall_i        (stall_i),
      .redirect_i     (redirect_i),
      .redirect_addr_i(redirect_addr_i),
      .imem_req_o     (imem_req_o),
      .imem_addr_o    (imem_addr_o),
      .imem_ack_i     (imem_ack_i),
      .imem_data_i    (imem_data_i),
      .instr_addr_o   (instr_addr_o),
      .instr_o        (instr_o),
      .valid_o        (valid_o)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
      end
   endtask

   // One clock cycle: drive inputs after the edge, compare at mid-cycle, advance model.
   task automatic cycle(input logic r, input logic a, input logic s, input logic rd,
                        input logic [31:0] ra);
      logic        e_req, e_valid;
      logic [31:0] e_addr, e_instr, e_iaddr, ram;
      @(posedge clk_i);
      #1;
      rst_i           = r;
      imem_ack_i      = a;
      stall_i         = s;
      redirect_i      = rd;
      redirect_addr_i = ra;
      imem_data_i     = $urandom;
      #4;
      ram     = ra & 32'hFFFF_FFFC;
      e_req   = 1'b0;
      e_valid = 1'b0;
      e_addr  = 32'h0;
      e_instr = 32'h0;
      e_iaddr = 32'h0;
      if (r) begin
         m_pc       = 32'h0;
         m_flushing = 1'b0;
         m_tgt      = 32'h0;
         m_held     = 1'b0;
      end else if (m_held) begin
         e_valid = ~rd;
         e_instr = m_held_instr;
         e_iaddr = m_held_addr;
         if (rd) begin
            m_pc   = ram;
            m_held = 1'b0;
         end else if (!s) begin
            m_held = 1'b0;
         end
      end else if (m_flushing) begin
         e_req  = 1'b1;
         e_addr = m_pc;
         if (rd) m_tgt = ram;
         if (a) begin
            m_pc       = m_tgt;
            m_flushing = 1'b0;
         end
      end else begin
         e_req   = 1'b1;
         e_addr  = m_pc;
         e_valid = a & ~rd;
         e_instr = imem_data_i;
         e_iaddr = m_pc;
         if (a && rd) begin
            m_pc = ram;
         end else if (a) begin
            if (s) begin
               m_held       = 1'b1;
               m_held_addr  = m_pc;
               m_held_instr = imem_data_i;
            end
            m_pc = m_pc + 32'd4;
         end else if (rd) begin
            m_flushing = 1'b1;
            m_tgt      = ram;
         end
      end
      check("imem_req", {31'h0, imem_req_o}, {31'h0, e_req});
      if (e_req) check("imem_addr", imem_addr_o, e_addr);
      check("valid", {31'h0, valid_o}, {31'h0, e_valid});
      if (e_valid) begin
         check("instr", instr_o, e_instr);
         check("instr_addr", instr_addr_o, e_iaddr);
      end
      if (r) begin
         check("rst_instr", instr_o, 32'h0);
         check("rst_iaddr", instr_addr_o, 32'h0);
      end
   endtask

   initial begin
      // Reset held
      cycle(1, 0, 0, 0, 0);
      check("lit_rst_req", {31'h0, imem_req_o}, 32'h0);
      cycle(1, 1, 0, 0, 0);
      check("lit_rst_valid", {31'h0, valid_o}, 32'h0);
      // Zero-wait back-to-back fetch
      cycle(0, 1, 0, 0, 0);
      check("lit_addr0", imem_addr_o, 32'h0);
      check("lit_valid0", {31'h0, valid_o}, 32'h1);
      cycle(0, 1, 0, 0, 0);
      check("lit_iaddr4", instr_addr_o, 32'h4);
      // Three-cycle latency at 0x8
      cycle(0, 0, 0, 0, 0);
      check("lit_wait_addr", imem_addr_o, 32'h8);
      check("lit_wait_valid", {31'h0, valid_o}, 32'h0);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0);
      check("lit_lat_iaddr", instr_addr_o, 32'h8);
      // Stall on ack of 0xC for two cycles
      cycle(0, 1, 1, 0, 0);
      cycle(0, 0, 1, 0, 0);
      check("lit_hold_req", {31'h0, imem_req_o}, 32'h0);
      check("lit_hold_iaddr", instr_addr_o, 32'hC);
      cycle(0, 0, 0, 0, 0);
      check("lit_rel_valid", {31'h0, valid_o}, 32'h1);
      cycle(0, 0, 0, 0, 0);
      check("lit_after_rel", imem_addr_o, 32'h10);
      // Redirect while 0x10 outstanding, then a second redirect during the drop
      cycle(0, 0, 0, 1, 32'h100);
      check("lit_redir_valid", {31'h0, valid_o}, 32'h0);
      cycle(0, 0, 0, 1, 32'h200);
      check("lit_drop_addr", imem_addr_o, 32'h10);
      cycle(0, 1, 0, 0, 0);
      check("lit_drop_ack", {31'h0, valid_o}, 32'h0);
      cycle(0, 1, 0, 0, 0);
      check("lit_tgt_addr", imem_addr_o, 32'h200);
      // Redirect together with stall while holding
      cycle(0, 1, 1, 0, 0);
      cycle(0, 0, 1, 1, 32'h303);
      check("lit_hold_redir", {31'h0, valid_o}, 32'h0);
      cycle(0, 1, 0, 0, 0);
      check("lit_hold_tgt", imem_addr_o, 32'h300);
      // Reset pulse mid-wait
      cycle(0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      check("lit_midrst_req", {31'h0, imem_req_o}, 32'h0);
      cycle(0, 1, 0, 0, 0);
      check("lit_postrst", imem_addr_o, 32'h0);
      // PC wrap
      cycle(0, 1, 0, 1, 32'hFFFF_FFFC);
      cycle(0, 1, 0, 0, 0);
      check("lit_wrap_top", imem_addr_o, 32'hFFFF_FFFC);
      cycle(0, 1, 0, 0, 0);
      check("lit_wrap_zero", imem_addr_o, 32'h0);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         cycle(($urandom_range(0, 199) == 0),
               ($urandom_range(0, 99) < 45),
               ($urandom_range(0, 99) < 30),
               ($urandom_range(0, 99) < 10),
               $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
